// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and defaults for the unified-memory port arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int c_addr_width      = 32;
    localparam int c_data_width      = 32;
    localparam int c_strb_width      = c_data_width / 8;
    localparam int c_burst_cnt_width = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_I = 2'd1,
        ISSUE_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } grant_e;

    typedef struct packed {
        logic                    we;
        logic [c_addr_width-1:0] addr;
        logic [c_data_width-1:0] wdata;
        logic [c_strb_width-1:0] wstrb;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_req_slot.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_req_slot
// Purpose : One-deep pending slot for a strobe-based requester.
// Revision: 1.0
// ============================================================================
module mem_arb_req_slot
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_strobe,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_complete,
    output logic                    o_pending,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_overlap
);

    logic                    r_pending;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    w_load;

    // A strobe coinciding with completion reuses the slot in the same edge.
    assign w_load    = i_strobe && (!r_pending || i_complete);
    assign o_overlap = i_strobe && r_pending && !i_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_load) begin
            r_pending <= 1'b1;
            r_we      <= i_we;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
            r_wstrb   <= i_wstrb;
        end else if (i_complete) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_we      = r_we;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one valid/ready memory port between fetch and load/store.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifetch_req_i,
    input  logic [ADDR_WIDTH-1:0]   ifetch_addr_i,
    output logic [DATA_WIDTH-1:0]   ifetch_rdata_o,
    output logic                    ifetch_ready_o,
    input  logic                    dmem_read_i,
    input  logic                    dmem_write_i,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    mem_valid_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    proto_err_o
);

    localparam logic [c_burst_cnt_width-1:0] c_burst_max = c_burst_cnt_width'(DATA_BURST_MAX);

    logic                    w_i_pending, w_i_we, w_i_overlap, w_i_complete;
    logic [ADDR_WIDTH-1:0]   w_i_addr;
    logic [DATA_WIDTH-1:0]   w_i_wdata;
    logic [DATA_WIDTH/8-1:0] w_i_wstrb;

    logic                    w_d_pending, w_d_we, w_d_overlap, w_d_complete;
    logic [ADDR_WIDTH-1:0]   w_d_addr;
    logic [DATA_WIDTH-1:0]   w_d_wdata;
    logic [DATA_WIDTH/8-1:0] w_d_wstrb;

    logic                    w_d_strobe;
    logic                    w_dual_strobe;
    logic [DATA_WIDTH/8-1:0] w_d_wstrb_in;

    arb_state_e r_state, w_state_next;
    grant_e     w_grant;

    logic [c_burst_cnt_width-1:0] r_burst_cnt;
    logic                         r_mem_valid, r_mem_we;
    logic [ADDR_WIDTH-1:0]        r_mem_addr;
    logic [DATA_WIDTH-1:0]        r_mem_wdata;
    logic [DATA_WIDTH/8-1:0]      r_mem_wstrb;
    logic [DATA_WIDTH-1:0]        r_ifetch_rdata, r_dmem_rdata;
    logic                         r_ifetch_ready, r_dmem_ready;
    logic                         r_proto_err;

    // Read+write together is an error and resolves as a write; reads carry no byte enables.
    assign w_d_strobe    = dmem_read_i | dmem_write_i;
    assign w_dual_strobe = dmem_read_i & dmem_write_i;
    assign w_d_wstrb_in  = dmem_write_i ? dmem_wstrb_i : '0;

    assign w_i_complete = (r_state == ISSUE_I) && mem_ready_i;
    assign w_d_complete = (r_state == ISSUE_D) && mem_ready_i;

    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_instr (
        .clk        (clk),
        .rst        (rst),
        .i_strobe   (ifetch_req_i),
        .i_we       (1'b0),
        .i_addr     (ifetch_addr_i),
        .i_wdata    ('0),
        .i_wstrb    ('0),
        .i_complete (w_i_complete),
        .o_pending  (w_i_pending),
        .o_we       (w_i_we),
        .o_addr     (w_i_addr),
        .o_wdata    (w_i_wdata),
        .o_wstrb    (w_i_wstrb),
        .o_overlap  (w_i_overlap)
    );

    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_data (
        .clk        (clk),
        .rst        (rst),
        .i_strobe   (w_d_strobe),
        .i_we       (dmem_write_i),
        .i_addr     (dmem_addr_i),
        .i_wdata    (dmem_wdata_i),
        .i_wstrb    (w_d_wstrb_in),
        .i_complete (w_d_complete),
        .o_pending  (w_d_pending),
        .o_we       (w_d_we),
        .o_addr     (w_d_addr),
        .o_wdata    (w_d_wdata),
        .o_wstrb    (w_d_wstrb),
        .o_overlap  (w_d_overlap)
    );

    always_comb begin
        w_state_next = r_state;
        w_grant      = GRANT_NONE;
        case (r_state)
            IDLE: begin
                if (w_i_pending && w_d_pending) begin
                    w_grant = (r_burst_cnt == c_burst_max) ? GRANT_INSTR : GRANT_DATA;
                end else if (w_i_pending) begin
                    w_grant = GRANT_INSTR;
                end else if (w_d_pending) begin
                    w_grant = GRANT_DATA;
                end
                if (w_grant == GRANT_INSTR) begin
                    w_state_next = ISSUE_I;
                end else if (w_grant == GRANT_DATA) begin
                    w_state_next = ISSUE_D;
                end
            end
            ISSUE_I, ISSUE_D: begin
                if (mem_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt    <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wstrb    <= '0;
            r_ifetch_rdata <= '0;
            r_dmem_rdata   <= '0;
            r_ifetch_ready <= 1'b0;
            r_dmem_ready   <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            r_ifetch_ready <= 1'b0;
            r_dmem_ready   <= 1'b0;

            if (w_dual_strobe || w_i_overlap || w_d_overlap) begin
                r_proto_err <= 1'b1;
            end

            // Slot contents are frozen while pending, so latching at grant keeps mem_* stable.
            case (w_grant)
                GRANT_INSTR: begin
                    r_mem_valid <= 1'b1;
                    r_mem_we    <= w_i_we;
                    r_mem_addr  <= w_i_addr;
                    r_mem_wdata <= w_i_wdata;
                    r_mem_wstrb <= w_i_wstrb;
                end
                GRANT_DATA: begin
                    r_mem_valid <= 1'b1;
                    r_mem_we    <= w_d_we;
                    r_mem_addr  <= w_d_addr;
                    r_mem_wdata <= w_d_wdata;
                    r_mem_wstrb <= w_d_wstrb;
                end
                default: ;
            endcase

            if (w_i_complete) begin
                r_mem_valid    <= 1'b0;
                r_ifetch_rdata <= mem_rdata_i;
                r_ifetch_ready <= 1'b1;
            end
            if (w_d_complete) begin
                r_mem_valid  <= 1'b0;
                r_dmem_ready <= 1'b1;
                if (!r_mem_we) begin
                    r_dmem_rdata <= mem_rdata_i;
                end
            end

            // Burst count only tracks data grants that starve a waiting fetch.
            if (r_state == IDLE) begin
                if (!w_i_pending || w_grant == GRANT_INSTR) begin
                    r_burst_cnt <= '0;
                end else if (w_grant == GRANT_DATA) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_valid_o    = r_mem_valid;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign mem_wstrb_o    = r_mem_wstrb;
    assign ifetch_rdata_o = r_ifetch_rdata;
    assign ifetch_ready_o = r_ifetch_ready;
    assign dmem_rdata_o   = r_dmem_rdata;
    assign dmem_ready_o   = r_dmem_ready;
    assign proto_err_o    = r_proto_err;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester and its data-load/store requester.
- Both requesters use the core's native protocol: one-cycle request strobes, then a one-cycle ready pulse carrying the returned data.
- The block captures the strobes, arbitrates between them and drives a valid/ready downstream memory port.
- It sits between the multi-cycle core and the memory model or SRAM wrapper.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; wstrb width is DATA_WIDTH/8.
- DATA_BURST_MAX, 4, maximum consecutive data grants while an instruction request is pending; range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ifetch_req_i  in  1  one-cycle instruction read strobe.
- ifetch_addr_i  in  ADDR_WIDTH  fetch address; valid with the strobe.
- ifetch_rdata_o  out  DATA_WIDTH  fetched word; valid while ifetch_ready_o=1.
- ifetch_ready_o  out  1  one-cycle completion pulse.
- dmem_read_i  in  1  one-cycle load strobe.
- dmem_write_i  in  1  one-cycle store strobe.
- dmem_addr_i  in  ADDR_WIDTH  load/store address.
- dmem_wdata_i  in  DATA_WIDTH  store data.
- dmem_wstrb_i  in  DATA_WIDTH/8  store byte enables.
- dmem_rdata_o  out  DATA_WIDTH  load data; valid while dmem_ready_o=1.
- dmem_ready_o  out  1  one-cycle completion pulse, for loads and stores.
- mem_valid_o  out  1  downstream request valid.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_WIDTH  downstream address.
- mem_wdata_o  out  DATA_WIDTH  downstream write data.
- mem_wstrb_o  out  DATA_WIDTH/8  downstream byte enables; all zero on reads.
- mem_rdata_i  in  DATA_WIDTH  downstream read data; valid when mem_valid_o and mem_ready_i are both 1.
- mem_ready_i  in  1  downstream accept/complete; the transfer occurs when mem_valid_o and mem_ready_i are both 1.
- proto_err_o  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0, both pending slots clear, the FSM goes to IDLE and the burst counter goes to 0.
  - An in-flight downstream transfer is abandoned; mem_valid_o is 0 in the cycle after reset.
  - No ready pulse is generated for an abandoned request.
- Capture:
  - Each requester has one pending slot holding address and, for data, we/wdata/wstrb.
  - A strobe at edge T loads the slot.
  - A strobe to an occupied slot is ignored and sets proto_err_o.
  - A strobe in the same cycle as that slot's completion handshake is accepted: the slot is reloaded, not cleared.
  - dmem_read_i and dmem_write_i both high together sets proto_err_o; the request is treated as a write.
- FSM states: IDLE, ISSUE_I, ISSUE_D.
  - IDLE: if any slot is pending, choose a grant and move to ISSUE_I or ISSUE_D. mem_valid_o is 0 in IDLE.
  - ISSUE_x: mem_valid_o=1, and mem_* is driven from slot x, held stable until mem_ready_i=1.
  - On the handshake: clear slot x (or reload it per the capture rule) and go to IDLE.
  - There are no back-to-back issues; one IDLE cycle always separates transfers.
- Arbitration in IDLE:
  - If only one slot is pending, grant it.
  - If both are pending, grant data unless burst_cnt==DATA_BURST_MAX, in which case grant instruction.
  - burst_cnt increments on each data grant made while the instruction slot is pending.
  - burst_cnt resets to 0 on any instruction grant, and whenever the instruction slot is empty at arbitration.
- Response:
  - At the handshake edge, mem_rdata_i is registered into ifetch_rdata_o or dmem_rdata_o.
  - The matching ready output pulses for exactly one cycle after that edge.
  - For writes, dmem_rdata_o keeps its previous value and dmem_ready_o still pulses.
- Latency:
  - Strobe at cycle T (captured at the T edge); IDLE during T+1; mem_valid_o=1 at T+2.
  - If mem_ready_i=1 at T+2, ready pulses at T+3. Minimum strobe-to-ready latency is 3 cycles.
  - Each wait cycle on mem_ready_i adds one cycle.
- The mem_* outputs are registered, with no combinational path from any requester input.
- mem_addr_o, mem_wdata_o and mem_wstrb_o are don't-care when mem_valid_o=0; the bench must not check them.

Decomposition:
- Shared package mem_arb_pkg contains:
  - arb_state_e {IDLE, ISSUE_I, ISSUE_D}
  - grant_e {GRANT_NONE, GRANT_INSTR, GRANT_DATA}
  - packed struct mem_req_t {we, addr, wdata, wstrb}, parameterised via the package constants defaults.
- One sub-module, mem_arb_req_slot, is instantiated twice. It handles strobe capture, pending flag, overlap error and reload-on-complete.
- Arbitration, FSM and response registers live in the top module.

Test Plan:
- Single fetch: ifetch_req_i at addr 0x40, mem_ready_i tied 1, memory[0x40]=0x00500093 -> mem_valid_o at T+2; ifetch_ready_o pulse at T+3 with rdata 0x00500093; proto_err_o=0.
- Store then load: store 0xDEADBEEF, wstrb 4'b0011, to 0x100; then load 0x100 with preset 0 -> mem_we_o=1 and mem_wstrb_o=0011 on the write; dmem_ready_o pulses twice; load returns 0x0000BEEF.
- Simultaneous requests: ifetch 0x0 and dmem_read 0x200 in the same cycle -> the data transfer is issued first; the fetch issues after one IDLE cycle; each ready pulses once, in that order.
- Fairness with DATA_BURST_MAX=2: instruction request held pending, data re-strobed on every completion -> grant order D, D, I, D, ...
- Backpressure and reset: mem_ready_i held 0 for 5 cycles -> mem_* stable throughout; then rst=1 mid-transfer -> mem_valid_o=0 next cycle, no ready pulse, slots empty.
- Protocol error: second ifetch_req_i while the fetch is pending -> ignored, proto_err_o=1 and sticky; only one ifetch_ready_o pulse.
